// File: rtl/dom_sqscmul_gf2_sched_pkg.sv
// Shared width helpers for the masked GF(2^2) square-scale-multiply scheduler.
package dom_sqscmul_gf2_sched_pkg;

  localparam int unsigned MaxNreq = 8;

  function automatic int unsigned ctrl_clog2(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

  // A single requester still needs a 1-bit id field.
  function automatic int unsigned id_width(input int unsigned nreq);
    return (nreq > 1) ? ctrl_clog2(nreq) : 1;
  endfunction

  function automatic int unsigned z_width(input int unsigned shares);
    return shares * (shares - 1);
  endfunction

  function automatic int unsigned blind_nrnd(input int unsigned shares);
    return (shares * (shares - 1)) / 2;
  endfunction

endpackage

// File: rtl/dom_sqscmul_gf2_sched_if.sv
// Requester, randomness and multiplier-side signals of the scheduler.
interface dom_sqscmul_gf2_sched_if #(
  parameter int unsigned SHARES = 2,
  parameter int unsigned NREQ   = 4
);
  import dom_sqscmul_gf2_sched_pkg::*;

  localparam int unsigned IDW  = id_width(NREQ);
  localparam int unsigned ZW   = z_width(SHARES);
  localparam int unsigned BRND = blind_nrnd(SHARES);

  logic [NREQ-1:0]          req;
  logic [NREQ*4*SHARES-1:0] x;
  logic [NREQ-1:0]          gnt;
  logic                     rnd_valid;
  logic [ZW+2*BRND-1:0]     rnd;
  logic                     rnd_take;
  logic [4*SHARES-1:0]      mul_x;
  logic [ZW-1:0]            mul_z;
  logic [2*BRND-1:0]        mul_b;
  logic [2*SHARES-1:0]      mul_q;
  logic [NREQ-1:0]          rsp_valid;
  logic [IDW-1:0]           rsp_id;
  logic [2*SHARES-1:0]      q;

  modport slave (
    input  req, x, rnd_valid, rnd, mul_q,
    output gnt, rnd_take, mul_x, mul_z, mul_b, rsp_valid, rsp_id, q
  );

  modport master (
    output req, x, rnd_valid, rnd, mul_q,
    input  gnt, rnd_take, mul_x, mul_z, mul_b, rsp_valid, rsp_id, q
  );

endinterface

// File: rtl/dom_sqscmul_gf2_sched_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer advances past each winner.
module dom_sqscmul_gf2_sched_rr_arbiter
  import dom_sqscmul_gf2_sched_pkg::*;
#(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IDW  = id_width(NREQ)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_en,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_id
);

  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] w_ptr_nxt;
  logic [IDW-1:0] w_idx;
  logic [IDW-1:0] w_cand;
  logic           w_found;
  logic           w_fire;

  // Scan from the pointer upward with wrap; first requester found wins.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_cand  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_cand = IDW'((32'(r_ptr) + k) % NREQ);
      if (!w_found && i_req[w_cand]) begin
        w_found = 1'b1;
        w_idx   = w_cand;
      end
    end
  end

  assign w_fire    = i_en & w_found;
  assign o_id      = w_idx;
  assign w_ptr_nxt = (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + 1'b1;

  always_comb begin
    o_gnt = '0;
    if (w_fire) o_gnt[w_idx] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (w_fire) begin
      r_ptr <= w_ptr_nxt;
    end
  end

endmodule

// File: rtl/dom_sqscmul_gf2_sched.sv
// Shares one pipelined masked GF(2^2) sqscmul unit between NREQ requesters; results
// return tagged with the owner id after LATENCY cycles.
module dom_sqscmul_gf2_sched
  import dom_sqscmul_gf2_sched_pkg::*;
#(
  parameter int unsigned SHARES  = 2,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned LATENCY = 1
) (
  input logic                   i_clk,
  input logic                   i_rst_n,
  dom_sqscmul_gf2_sched_if.slave io_bus
);

  localparam int unsigned IDW  = id_width(NREQ);
  localparam int unsigned ZW   = z_width(SHARES);
  localparam int unsigned BRND = blind_nrnd(SHARES);
  localparam int unsigned OPW  = 4 * SHARES;
  localparam int unsigned QW   = 2 * SHARES;

  logic            w_issue;
  logic [NREQ-1:0] w_gnt;
  logic [IDW-1:0]  w_win;
  logic [OPW-1:0]  w_mul_x;
  logic            r_vld [LATENCY];
  logic [IDW-1:0]  r_id  [LATENCY];
  logic            w_last_vld;
  logic [IDW-1:0]  w_last_id;

  assign w_issue = io_bus.rnd_valid & (|io_bus.req);

  dom_sqscmul_gf2_sched_rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_req  (io_bus.req),
    .i_en   (io_bus.rnd_valid),
    .o_gnt  (w_gnt),
    .o_id   (w_win)
  );

  // AND-OR select keeps every share on its own wires; shares are never combined.
  always_comb begin
    w_mul_x = '0;
    for (int unsigned r = 0; r < NREQ; r++) begin
      w_mul_x = w_mul_x | ({OPW{w_gnt[r]}} & io_bus.x[r*OPW +: OPW]);
    end
  end

  assign io_bus.gnt      = w_gnt;
  assign io_bus.rnd_take = w_issue;
  assign io_bus.mul_x    = w_mul_x;
  assign io_bus.mul_z    = {ZW{w_issue}} & io_bus.rnd[ZW-1:0];
  assign io_bus.mul_b    = {(2*BRND){w_issue}} & io_bus.rnd[ZW +: 2*BRND];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        r_vld[i] <= 1'b0;
        r_id[i]  <= '0;
      end
    end else begin
      r_vld[0] <= w_issue;
      r_id[0]  <= w_win;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_id[i]  <= r_id[i-1];
      end
    end
  end

  assign w_last_vld = r_vld[LATENCY-1];
  assign w_last_id  = r_id[LATENCY-1];

  always_comb begin
    io_bus.rsp_valid = '0;
    if (w_last_vld) io_bus.rsp_valid[w_last_id] = 1'b1;
  end

  assign io_bus.rsp_id = w_last_id;
  assign io_bus.q      = {QW{w_last_vld}} & io_bus.mul_q;

endmodule
